// File: rtl/hazard_scoreboard_pkg.sv
// Shared entry type and constants for the hazard scoreboard.
// Entry fields are sized to fixed maxima so one struct serves every parameterisation.
package hazard_pkg;

   localparam int ADDR_MAX_W = 8;
   localparam int CNT_MAX_W  = 4;

   localparam int FWD_RF   = 0;
   localparam int LAT_ALU  = 1;
   localparam int LAT_LOAD = 2;

   typedef struct packed {
      logic                  valid;
      logic                  wr;
      logic [ADDR_MAX_W-1:0] addr;
      logic [CNT_MAX_W-1:0]  cnt;
   } sb_entry_t;

   function automatic logic [CNT_MAX_W-1:0] cnt_dec(input logic [CNT_MAX_W-1:0] c);
      return (c == '0) ? c : c - CNT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the decode stage and the hazard scoreboard.
// The master side is decode or a testbench; the slave side is the scoreboard.
interface hazard_scoreboard_if #(
   parameter int REG_W  = 3,
   parameter int NUM_RD = 2,
   parameter int DEPTH  = 3,
   parameter int LAT_W  = 2,
   parameter int SEL_W  = $clog2(DEPTH+1)
);
   logic                    ext_stall;
   logic                    flush;
   logic                    dec_valid;
   logic                    dec_wr;
   logic [REG_W-1:0]        dec_waddr;
   logic [LAT_W-1:0]        dec_lat;
   logic [NUM_RD-1:0]       rd_en;
   logic [NUM_RD*REG_W-1:0] rd_addr;
   logic [NUM_RD*SEL_W-1:0] fwd_sel;
   logic                    stall;
   logic                    err;

   modport master (
      output ext_stall, flush, dec_valid, dec_wr, dec_waddr, dec_lat, rd_en, rd_addr,
      input  fwd_sel, stall, err
   );

   modport slave (
      input  ext_stall, flush, dec_valid, dec_wr, dec_waddr, dec_lat, rd_en, rd_addr,
      output fwd_sel, stall, err
   );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Youngest-match priority search for one read port over the tracked stages.
// search_mask bit j enables stage j+1; the lowest enabled matching stage wins.
module sb_port_match
   import hazard_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int SEL_W = $clog2(DEPTH+1)
) (
   input  sb_entry_t [DEPTH-1:0] ent,
   input  logic [DEPTH-1:0]      search_mask,
   input  logic                  en,
   input  logic [ADDR_MAX_W-1:0] addr,
   output logic                  hit,
   output logic                  ready,
   output logic [SEL_W-1:0]      stage
);

   always_comb begin
      hit   = 1'b0;
      ready = 1'b0;
      stage = '0;
      // Walk oldest to youngest so the youngest match is the last one written.
      for (int j = DEPTH-1; j >= 0; j--) begin
         if (en && search_mask[j] && ent[j].valid && ent[j].wr && (ent[j].addr == addr)) begin
            hit   = 1'b1;
            ready = (ent[j].cnt == '0);
            stage = SEL_W'(j+1);
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight writes across DEPTH stages and
// produces per-port forward selects and a decode stall. Macro: HAZ_REGFILE_BYPASS_EN.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_W  = 3,
   parameter int NUM_RD = 2,
   parameter int DEPTH  = 3,
   parameter int LAT_W  = 2,
   parameter int SEL_W  = $clog2(DEPTH+1)
) (
   input logic                clk,
   input logic                rst,
   hazard_scoreboard_if.slave bus
);

`ifdef HAZ_REGFILE_BYPASS_EN
   localparam logic [DEPTH-1:0] SEARCH_MASK = {DEPTH{1'b1}};
`else
   // Register file is write-before-read, so the WB stage never needs forwarding.
   localparam logic [DEPTH-1:0] SEARCH_MASK = {DEPTH{1'b1}} >> 1;
`endif

   sb_entry_t [DEPTH-1:0]             ent;
   sb_entry_t [DEPTH-1:0]             ent_nxt;
   logic                              err_q;
   logic                              err_nxt;
   logic [NUM_RD-1:0]                 hit;
   logic [NUM_RD-1:0]                 ready;
   logic [NUM_RD-1:0][SEL_W-1:0]      stage;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_port
      sb_port_match #(
         .DEPTH (DEPTH),
         .SEL_W (SEL_W)
      ) u_match (
         .ent         (ent),
         .search_mask (SEARCH_MASK),
         .en          (bus.rd_en[i]),
         .addr        (ADDR_MAX_W'(bus.rd_addr[i*REG_W +: REG_W])),
         .hit         (hit[i]),
         .ready       (ready[i]),
         .stage       (stage[i])
      );
   end

   always_comb begin
      bus.fwd_sel = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         bus.fwd_sel[i*SEL_W +: SEL_W] = (hit[i] && ready[i]) ? stage[i] : SEL_W'(FWD_RF);
      end
   end

   assign bus.stall = bus.dec_valid & |(hit & ~ready);
   assign bus.err   = err_q;

   always_comb begin
      ent_nxt = ent;
      err_nxt = err_q;
      if (!bus.ext_stall) begin
         for (int j = DEPTH-1; j >= 1; j--) begin
            ent_nxt[j]     = ent[j-1];
            ent_nxt[j].cnt = cnt_dec(ent[j-1].cnt);
            // The instruction leaving stage 1 on a redirect is wrong-path.
            if (j == 1 && bus.flush) begin
               ent_nxt[j].valid = 1'b0;
            end
         end
         ent_nxt[0].valid = bus.dec_valid & ~bus.stall & ~bus.flush;
         ent_nxt[0].wr    = bus.dec_wr;
         ent_nxt[0].addr  = ADDR_MAX_W'(bus.dec_waddr);
         // An illegal zero latency is flagged below and tracked as ready.
         ent_nxt[0].cnt   = (bus.dec_lat == '0) ? '0 : CNT_MAX_W'(bus.dec_lat - LAT_W'(1));
      end
      if (bus.dec_valid && bus.dec_wr && (bus.dec_lat == '0)) begin
         err_nxt = 1'b1;
      end
      if (int'(bus.dec_lat) > DEPTH) begin
         err_nxt = 1'b1;
      end
      // A writer still counting with fewer stages left than its count can never become ready.
      for (int j = 0; j < DEPTH; j++) begin
         if (ent[j].valid && ent[j].wr && (int'(ent[j].cnt) > DEPTH-1-j)) begin
            err_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent   <= '0;
         err_q <= 1'b0;
      end else begin
         ent   <= ent_nxt;
         err_q <= err_nxt;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=3, two read ports).
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_hazard_scoreboard;
   import hazard_pkg::*;

`ifdef HAZ_REGFILE_BYPASS_EN
   localparam logic [1:0] WB_SEL = 2'd3;
`else
   localparam logic [1:0] WB_SEL = 2'd0;
`endif

   logic clk;
   logic rst;
   int   passed;
   int   total;

   hazard_scoreboard_if #(.REG_W(3), .NUM_RD(2), .DEPTH(3), .LAT_W(2)) bus ();

   hazard_scoreboard #(
      .REG_W  (3),
      .NUM_RD (2),
      .DEPTH  (3),
      .LAT_W  (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_dec(input logic v, input logic wr, input logic [2:0] wa,
                          input logic [1:0] lat, input logic [1:0] en,
                          input logic [2:0] a0, input logic [2:0] a1);
      bus.dec_valid = v;
      bus.dec_wr    = wr;
      bus.dec_waddr = wa;
      bus.dec_lat   = lat;
      bus.rd_en     = en;
      bus.rd_addr   = {a1, a0};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bus.ext_stall = 1'b0;
      bus.flush     = 1'b0;
      set_dec(1'b0, 1'b0, 3'd0, 2'd1, 2'b00, 3'd0, 3'd0);
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.ext_stall = 1'b0;
      bus.flush     = 1'b0;
      set_dec(1'b1, 1'b0, 3'd0, 2'd1, 2'b11, 3'd3, 3'd4);
      @(negedge clk);
      total++; if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.stall); else passed++;
      total++; if (bus.fwd_sel !== 4'b0000) $display("FAIL reset_fwd: got %b want 0000", bus.fwd_sel); else passed++;
      total++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err); else passed++;
      rst = 1'b1;
      tick();
      drain();
   endtask

   task automatic test_alu_b2b();
      set_dec(1'b1, 1'b1, 3'd3, 2'(LAT_ALU), 2'b00, 3'd0, 3'd0);
      @(negedge clk);
      total++; if (bus.stall !== 1'b0) $display("FAIL alu_issue_stall: got %b want 0", bus.stall); else passed++;
      tick();
      set_dec(1'b1, 1'b0, 3'd0, 2'd1, 2'b01, 3'd3, 3'd0);
      @(negedge clk);
      total++; if (bus.stall !== 1'b0) $display("FAIL alu_s1_stall: got %b want 0", bus.stall); else passed++;
      total++; if (bus.fwd_sel !== 4'b0001) $display("FAIL alu_s1_fwd: got %b want 0001", bus.fwd_sel); else passed++;
      tick();
      @(negedge clk);
      total++; if (bus.stall !== 1'b0) $display("FAIL alu_s2_stall: got %b want 0", bus.stall); else passed++;
      total++; if (bus.fwd_sel !== 4'b0010) $display("FAIL alu_s2_fwd: got %b want 0010", bus.fwd_sel); else passed++;
      tick();
      @(negedge clk);
      total++; if (bus.stall !== 1'b0) $display("FAIL alu_wb_stall: got %b want 0", bus.stall); else passed++;
      total++; if (bus.fwd_sel !== {2'b00, WB_SEL}) $display("FAIL alu_wb_fwd: got %b want %b", bus.fwd_sel, {2'b00, WB_SEL}); else passed++;
      tick();
      drain();
   endtask

   task automatic test_load_use();
      set_dec(1'b1, 1'b1, 3'd2, 2'(LAT_LOAD), 2'b00, 3'd0, 3'd0);
      @(negedge clk);
      total++; if (bus.stall !== 1'b0) $display("FAIL load_issue_stall: got %b want 0", bus.stall); else passed++;
      tick();
      set_dec(1'b1, 1'b0, 3'd0, 2'd1, 2'b10, 3'd0, 3'd2);
      @(negedge clk);
      total++; if (bus.stall !== 1'b1) $display("FAIL load_use_stall: got %b want 1", bus.stall); else passed++;
      total++; if (bus.fwd_sel !== 4'b0000) $display("FAIL load_use_fwd: got %b want 0000", bus.fwd_sel); else passed++;
      tick();
      @(negedge clk);
      total++; if (bus.stall !== 1'b0) $display("FAIL load_after_stall: got %b want 0", bus.stall); else passed++;
      total++; if (bus.fwd_sel !== 4'b1000) $display("FAIL load_after_fwd: got %b want 1000", bus.fwd_sel); else passed++;
      tick();
      @(negedge clk);
      total++; if (bus.fwd_sel !== {WB_SEL, 2'b00}) $display("FAIL load_wb_fwd: got %b want %b", bus.fwd_sel, {WB_SEL, 2'b00}); else passed++;
      tick();
      drain();
   endtask

   task automatic test_youngest_wins();
      set_dec(1'b1, 1'b1, 3'd5, 2'(LAT_ALU), 2'b00, 3'd0, 3'd0);
      tick();
      set_dec(1'b1, 1'b1, 3'd5, 2'(LAT_LOAD), 2'b00, 3'd0, 3'd0);
      @(negedge clk);
      total++; if (bus.stall !== 1'b0) $display("FAIL young_noread_stall: got %b want 0", bus.stall); else passed++;
      tick();
      set_dec(1'b1, 1'b0, 3'd0, 2'd1, 2'b01, 3'd5, 3'd0);
      @(negedge clk);
      total++; if (bus.stall !== 1'b1) $display("FAIL young_stall: got %b want 1", bus.stall); else passed++;
      total++; if (bus.fwd_sel !== 4'b0000) $display("FAIL young_fwd: got %b want 0000", bus.fwd_sel); else passed++;
      tick();
      @(negedge clk);
      total++; if (bus.stall !== 1'b0) $display("FAIL young_after_stall: got %b want 0", bus.stall); else passed++;
      total++; if (bus.fwd_sel !== 4'b0010) $display("FAIL young_after_fwd: got %b want 0010", bus.fwd_sel); else passed++;
      tick();
      drain();
   endtask

   task automatic test_flush_during_stall();
      set_dec(1'b1, 1'b1, 3'd6, 2'(LAT_ALU), 2'b00, 3'd0, 3'd0);
      tick();
      set_dec(1'b1, 1'b1, 3'd2, 2'(LAT_LOAD), 2'b00, 3'd0, 3'd0);
      tick();
      set_dec(1'b1, 1'b0, 3'd0, 2'd1, 2'b10, 3'd0, 3'd2);
      bus.flush = 1'b1;
      @(negedge clk);
      total++; if (bus.stall !== 1'b1) $display("FAIL flush_pre_stall: got %b want 1", bus.stall); else passed++;
      tick();
      bus.flush = 1'b0;
      set_dec(1'b1, 1'b0, 3'd0, 2'd1, 2'b11, 3'd6, 3'd2);
      @(negedge clk);
      total++; if (bus.stall !== 1'b0) $display("FAIL flush_post_stall: got %b want 0", bus.stall); else passed++;
      total++; if (bus.fwd_sel !== {2'b00, WB_SEL}) $display("FAIL flush_post_fwd: got %b want %b", bus.fwd_sel, {2'b00, WB_SEL}); else passed++;
      tick();
      drain();
   endtask

   task automatic test_ext_stall_hold();
      set_dec(1'b1, 1'b1, 3'd1, 2'(LAT_LOAD), 2'b00, 3'd0, 3'd0);
      tick();
      bus.ext_stall = 1'b1;
      set_dec(1'b0, 1'b0, 3'd0, 2'd1, 2'b01, 3'd1, 3'd0);
      @(negedge clk);
      total++; if (bus.stall !== 1'b0) $display("FAIL hold1_stall: got %b want 0", bus.stall); else passed++;
      total++; if (bus.fwd_sel !== 4'b0000) $display("FAIL hold1_fwd: got %b want 0000", bus.fwd_sel); else passed++;
      tick();
      set_dec(1'b1, 1'b0, 3'd0, 2'd1, 2'b01, 3'd1, 3'd0);
      bus.flush = 1'b1;
      @(negedge clk);
      total++; if (bus.stall !== 1'b1) $display("FAIL hold2_stall: got %b want 1", bus.stall); else passed++;
      total++; if (bus.fwd_sel !== 4'b0000) $display("FAIL hold2_fwd: got %b want 0000", bus.fwd_sel); else passed++;
      tick();
      bus.flush = 1'b0;
      @(negedge clk);
      total++; if (bus.stall !== 1'b1) $display("FAIL hold3_stall: got %b want 1", bus.stall); else passed++;
      total++; if (bus.fwd_sel !== 4'b0000) $display("FAIL hold3_fwd: got %b want 0000", bus.fwd_sel); else passed++;
      tick();
      bus.ext_stall = 1'b0;
      @(negedge clk);
      total++; if (bus.stall !== 1'b1) $display("FAIL resume_stall: got %b want 1", bus.stall); else passed++;
      total++; if (bus.fwd_sel !== 4'b0000) $display("FAIL resume_fwd: got %b want 0000", bus.fwd_sel); else passed++;
      tick();
      @(negedge clk);
      total++; if (bus.stall !== 1'b0) $display("FAIL resume2_stall: got %b want 0", bus.stall); else passed++;
      total++; if (bus.fwd_sel !== 4'b0010) $display("FAIL resume2_fwd: got %b want 0010", bus.fwd_sel); else passed++;
      tick();
      drain();
   endtask

   task automatic test_err_sticky();
      @(negedge clk);
      total++; if (bus.err !== 1'b0) $display("FAIL err_clean: got %b want 0", bus.err); else passed++;
      tick();
      set_dec(1'b1, 1'b1, 3'd7, 2'd0, 2'b00, 3'd0, 3'd0);
      tick();
      set_dec(1'b0, 1'b0, 3'd0, 2'd1, 2'b00, 3'd0, 3'd0);
      @(negedge clk);
      total++; if (bus.err !== 1'b1) $display("FAIL err_set: got %b want 1", bus.err); else passed++;
      drain();
      @(negedge clk);
      total++; if (bus.err !== 1'b1) $display("FAIL err_sticky: got %b want 1", bus.err); else passed++;
      rst = 1'b0;
      #2;
      total++; if (bus.err !== 1'b0) $display("FAIL err_reset: got %b want 0", bus.err); else passed++;
      total++; if (bus.stall !== 1'b0) $display("FAIL err_reset_stall: got %b want 0", bus.stall); else passed++;
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_alu_b2b();
      test_load_use();
      test_youngest_wins();
      test_flush_during_stall();
      test_ext_stall_hold();
      test_err_sticky();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order pipeline.
- Sits between decode and the execute-stage operand muxes.
- Tracks every in-flight register write across DEPTH post-decode stages, each with its own result-ready latency.
- For each decode read port it produces a forward select (register file or stage k), a load-use/multi-cycle stall, and a flush-aware bubble insertion.
- Generalises the fixed 2-port, single-load-latency forwarding/stall logic to N read ports, arbitrary depth and per-instruction latency.

Parameters:
- REG_W, 3, register address width (2**REG_W architectural registers).
- NUM_RD, 2, decode read ports.
- DEPTH, 3, tracked stages after decode (1 = EX ... DEPTH = WB).
- LAT_W, 2, width of the issue latency field.
- SEL_W, $clog2(DEPTH+1), width of one forward select.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (one clock domain; reset asserted when rst=0)
- ext_stall  in  1  global freeze (instruction/data memory stall); no state changes
- flush  in  1  redirect taken in EX; squash decode and stage 1
- dec_valid  in  1  decode holds a real instruction
- dec_wr  in  1  decode instruction writes a register
- dec_waddr  in  REG_W  its destination
- dec_lat  in  LAT_W  stages after decode until its result is forwardable (ALU=1, load=2); 0 is illegal
- rd_en  in  NUM_RD  read port i is used
- rd_addr  in  NUM_RD*REG_W  read addresses, port i at [i*REG_W +: REG_W]
- fwd_sel  out  NUM_RD*SEL_W  0 = register file, k = stage k result
- stall  out  1  hold fetch/decode, inject bubble into stage 1
- err  out  1  illegal condition seen (sticky until reset)

Behaviour:
- State: DEPTH entries {valid, wr, addr[REG_W], cnt[LAT_W]}; entry k is the instruction in stage k.
- Reset (rst=0, async): all entries cleared; stall=0, fwd_sel=0, err=0.
- Match: entry k matches port i when valid & wr & addr==rd_addr[i] & rd_en[i].
- Youngest match wins: smallest k.
- Entry ready when cnt==0.
- Forward select (combinational, same cycle):
  - fwd_sel[i] = k of the youngest match if it is ready; otherwise 0.
  - No match gives 0.
- Stall (combinational): stall = dec_valid & any port whose youngest match is not ready. Data cannot be forwarded from an older stage past a pending younger writer.
- Advance (rising clk, ext_stall=0):
  - Entries k>=2 take entry k-1; cnt decrements, saturating at 0.
  - Entry 1 takes decode {dec_valid&~stall&~flush, dec_wr, dec_waddr, dec_lat-1}; otherwise a bubble (valid=0).
  - Entry DEPTH is discarded (written back).
- ext_stall=1: all entries hold. stall and fwd_sel are still driven from the current state. ext_stall has priority over flush; flush is applied on the first cycle with ext_stall=0 only if it is still asserted.
- flush=1 (ext_stall=0): entry 2 receives a bubble in place of the old entry 1 (the wrong-path instruction in EX). Entry 1 receives a bubble. Entries >=3 advance normally. flush overrides stall.
- Simultaneous stall and flush: flush wins, no bubble double-counting.
- err set when any of:
  - dec_valid & dec_wr & dec_lat==0
  - dec_lat > DEPTH
  - a ready entry has cnt underflow (cannot occur by construction; checked for robustness)
- Register 0 has no special meaning; all addresses are tracked.

Optional Feature:
- HAZ_REGFILE_BYPASS_EN
  - Defined: matches at stage DEPTH (WB) forward with fwd_sel=DEPTH.
  - Undefined: a WB-stage match returns fwd_sel=0. The register file is write-before-read, so WB entries are excluded from match search. A younger non-ready match still stalls.

Decomposition:
- Shared package hazard_pkg:
  - sb_entry_t struct {valid, wr, addr, cnt}
  - FWD_RF=0 constant
  - LAT_ALU=1, LAT_LOAD=2 constants
- One sub-module, sb_port_match: one read port's youngest-match priority search over DEPTH entries, returning {hit, ready, stage}. Instantiated NUM_RD times with generate.

Test Plan:
- ALU back-to-back: issue r3 (lat 1), next cycle read r3 on port 0 -> stall=0, fwd_sel[0]=1; one cycle later -> fwd_sel[0]=2.
- Load-use: issue load r2 (lat 2), next decode reads r2 on port 1 -> stall=1 for exactly one cycle, bubble in stage 1, then fwd_sel[1]=2, stall=0.
- Youngest wins: r5 written at stage 2 (ready) and stage 1 (load, cnt=1), read r5 -> stall=1 (not fwd_sel=2).
- Flush during stall: load-use stall plus flush=1 -> next cycle entries 1 and 2 invalid, stall=0, fwd_sel=0.
- ext_stall hold: ext_stall=1 for 3 cycles with a pending load -> entries unchanged, same stall/fwd_sel each cycle; resumes correctly afterwards.
- WB match with DEPTH=3: read r4 at stage 3 -> fwd_sel=3 with HAZ_REGFILE_BYPASS_EN, 0 without; dec_lat=0 issue -> err=1 and it stays 1 until rst=0.
